// File: rtl/pipe_result_accum.sv
// pipe_result_accum
//   Consumes the unsigned XW-bit result stream from the arithmetic pipeline.
//   It accumulates frames of N_SAMPLES valid samples and tracks each frame's
//   sum and maximum. Each completed frame is presented on a valid/ready port
//   through a single-entry output register. The upstream stage cannot be
//   stalled, so a frame that completes while the output register is still
//   occupied (and not being drained) is dropped and flagged on a sticky
//   overrun bit.
//
//   Optional build macro: ACC_AVG_EN adds acc_avg = frame_sum >> clog2(N_SAMPLES).
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   x_in       result sample (unsigned, XW bits)
//   x_valid    x_in valid this cycle
//   acc_sum    sum of the presented frame
//   acc_max    maximum of the presented frame
//   acc_avg    (ACC_AVG_EN only) truncated mean of the presented frame
//   out_valid  acc_* hold an unconsumed frame
//   out_ready  consumer takes the frame when out_valid & out_ready
//   sample_cnt samples collected so far in the working frame
//   overrun    sticky flag: a completed frame was dropped
module pipe_result_accum #(
    parameter int XW        = 14,
    parameter int N_SAMPLES = 8,
    parameter int SUMW      = 17
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XW-1:0]   x_in,
    input  logic            x_valid,
    output logic [SUMW-1:0] acc_sum,
    output logic [XW-1:0]   acc_max,
`ifdef ACC_AVG_EN
    output logic [XW-1:0]   acc_avg,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      sample_cnt,
    output logic            overrun
);

    localparam int         LOG2N = $clog2(N_SAMPLES);
    localparam logic [7:0] LAST  = 8'(N_SAMPLES - 1);

    // Elaboration-time parameter checks
    if (N_SAMPLES < 1 || N_SAMPLES > 256) begin : g_chk_n
        $error("pipe_result_accum: N_SAMPLES must be in 1..256");
    end
    if (SUMW < XW + LOG2N) begin : g_chk_sumw
        $error("pipe_result_accum: SUMW too narrow for XW + clog2(N_SAMPLES)");
    end
`ifdef ACC_AVG_EN
    if ((1 << LOG2N) != N_SAMPLES) begin : g_chk_pow2
        $error("pipe_result_accum: ACC_AVG_EN requires power-of-two N_SAMPLES");
    end
`endif

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state, state_nxt;
    logic [SUMW-1:0] wsum;
    logic [XW-1:0]   wmax;

    // Sum/max including the current sample; on the last sample of a frame
    // these are the frame's final values.
    logic [SUMW-1:0] nxt_sum;
    logic [XW-1:0]   nxt_max;
    logic            complete;
    logic            load;
    logic            drop;

    assign nxt_sum  = wsum + SUMW'(x_in);
    assign nxt_max  = (x_in > wmax) ? x_in : wmax;
    assign complete = x_valid && (sample_cnt == LAST);

    // Working accumulator: never stalls, restarts with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            wsum       <= '0;
            wmax       <= '0;
            sample_cnt <= '0;
        end else if (x_valid) begin
            if (complete) begin
                wsum       <= '0;
                wmax       <= '0;
                sample_cnt <= '0;
            end else begin
                wsum       <= nxt_sum;
                wmax       <= nxt_max;
                sample_cnt <= sample_cnt + 8'd1;
            end
        end
    end

    // Output register FSM: next state and load/drop decisions.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (complete) begin
                    load      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    // Draining frees the slot, so a same-cycle completion fits.
                    if (complete) load = 1'b1;
                    else          state_nxt = EMPTY;
                end else if (complete) begin
                    drop = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            acc_sum <= '0;
            acc_max <= '0;
`ifdef ACC_AVG_EN
            acc_avg <= '0;
`endif
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                acc_sum <= nxt_sum;
                acc_max <= nxt_max;
`ifdef ACC_AVG_EN
                acc_avg <= XW'(nxt_sum >> LOG2N);
`endif
            end
            if (drop) overrun <= 1'b1;
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_pipe_result_accum.sv
// Directed bench for pipe_result_accum. Two instances: the default N_SAMPLES=8
// build and an N_SAMPLES=1 build. Inputs change 1 time unit after the rising
// edge, and outputs are checked at that point, so each check observes the
// state registered by the preceding edge.
module tb_pipe_result_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] x_in;
    logic        x_valid;
    logic        out_ready;
    logic [16:0] acc_sum;
    logic [13:0] acc_max;
    logic        out_valid;
    logic [7:0]  sample_cnt;
    logic        overrun;

    logic [13:0] x1_in;
    logic        x1_valid;
    logic        out1_ready;
    logic [16:0] acc1_sum;
    logic [13:0] acc1_max;
    logic        out1_valid;
    logic [7:0]  sample1_cnt;
    logic        overrun1;
`ifdef ACC_AVG_EN
    logic [13:0] acc_avg;
    logic [13:0] acc1_avg;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_result_accum #(.XW(14), .N_SAMPLES(8), .SUMW(17)) dut (
        .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid),
        .acc_sum(acc_sum), .acc_max(acc_max),
`ifdef ACC_AVG_EN
        .acc_avg(acc_avg),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sample_cnt(sample_cnt), .overrun(overrun)
    );

    pipe_result_accum #(.XW(14), .N_SAMPLES(1), .SUMW(17)) dut1 (
        .clk(clk), .rst(rst), .x_in(x1_in), .x_valid(x1_valid),
        .acc_sum(acc1_sum), .acc_max(acc1_max),
`ifdef ACC_AVG_EN
        .acc_avg(acc1_avg),
`endif
        .out_valid(out1_valid), .out_ready(out1_ready),
        .sample_cnt(sample1_cnt), .overrun(overrun1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One valid sample into the N=8 instance.
    task automatic push(input logic [13:0] v);
        x_in    = v;
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; x_in = '0; x_valid = 1'b0; out_ready = 1'b0;
        x1_in = '0; x1_valid = 1'b0; out1_ready = 1'b0;
        #1;
        do_reset();

        // Reset state
        chk("rst_sum",   32'(acc_sum),    0);
        chk("rst_max",   32'(acc_max),    0);
        chk("rst_valid", 32'(out_valid),  0);
        chk("rst_cnt",   32'(sample_cnt), 0);
        chk("rst_ovr",   32'(overrun),    0);
`ifdef ACC_AVG_EN
        chk("rst_avg",   32'(acc_avg),    0);
`endif

        // Frame 1..8, out_ready low
        for (int i = 1; i <= 7; i++) push(14'(i));
        chk("f1_cnt7",   32'(sample_cnt), 7);
        chk("f1_nv7",    32'(out_valid),  0);
        push(14'd8);
        chk("f1_valid",  32'(out_valid),  1);
        chk("f1_sum",    32'(acc_sum),    36);
        chk("f1_max",    32'(acc_max),    8);
        chk("f1_cnt0",   32'(sample_cnt), 0);
`ifdef ACC_AVG_EN
        chk("f1_avg",    32'(acc_avg),    4);
`endif
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("f1_drain",  32'(out_valid),  0);
        chk("f1_keep",   32'(acc_sum),    36);

        // Gapped max-value frame
        for (int i = 0; i < 8; i++) begin
            x_in = 14'd16383; x_valid = 1'b1; tick();
            x_valid = 1'b0; tick();
            if (i == 3) chk("gap_cnt4", 32'(sample_cnt), 4);
        end
        chk("gap_valid", 32'(out_valid),  1);
        chk("gap_sum",   32'(acc_sum),    131064);
        chk("gap_max",   32'(acc_max),    16383);
        chk("gap_cnt0",  32'(sample_cnt), 0);
`ifdef ACC_AVG_EN
        chk("gap_avg",   32'(acc_avg),    16383);
`endif
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("gap_drain", 32'(out_valid),  0);

        // Overrun: frame 1 pending, frame 2 (8x5) completes undrained
        for (int i = 1; i <= 8; i++) push(14'(i));
        for (int i = 0; i < 8; i++) push(14'd5);
        chk("ovr_flag",  32'(overrun),    1);
        chk("ovr_sum",   32'(acc_sum),    36);
        chk("ovr_max",   32'(acc_max),    8);
        chk("ovr_valid", 32'(out_valid),  1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("ovr_drain", 32'(out_valid),  0);
        chk("ovr_stick", 32'(overrun),    1);
        do_reset();
        chk("ovr_clr",   32'(overrun),    0);

        // Handshake coincides with frame-2 completion
        for (int i = 1; i <= 8; i++) push(14'(i));
        for (int i = 0; i < 7; i++) push(14'd5);
        out_ready = 1'b1;
        push(14'd5);
        out_ready = 1'b0;
        chk("hs_valid",  32'(out_valid),  1);
        chk("hs_sum",    32'(acc_sum),    40);
        chk("hs_max",    32'(acc_max),    5);
        chk("hs_ovr",    32'(overrun),    0);
`ifdef ACC_AVG_EN
        chk("hs_avg",    32'(acc_avg),    5);
`endif
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("hs_drain",  32'(out_valid),  0);

        // Reset mid-frame discards the partial frame (rst wins over x_valid)
        for (int i = 0; i < 5; i++) push(14'd3);
        chk("mid_cnt5",  32'(sample_cnt), 5);
        x_in = 14'd9; x_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; x_valid = 1'b0;
        chk("mid_cnt0",  32'(sample_cnt), 0);
        chk("mid_sum",   32'(acc_sum),    0);
        chk("mid_max",   32'(acc_max),    0);
        chk("mid_valid", 32'(out_valid),  0);
        chk("mid_ovr",   32'(overrun),    0);
        for (int i = 0; i < 8; i++) push(14'd2);
        chk("post_valid", 32'(out_valid), 1);
        chk("post_sum",  32'(acc_sum),    16);
        chk("post_max",  32'(acc_max),    2);

        // N_SAMPLES=1 instance: every valid sample is a frame
        out1_ready = 1'b1;
        x1_in = 14'd7; x1_valid = 1'b1; tick();
        chk("n1_valid_a", 32'(out1_valid),  1);
        chk("n1_sum_a",   32'(acc1_sum),    7);
        chk("n1_cnt_a",   32'(sample1_cnt), 0);
        x1_in = 14'd3; tick();
        x1_valid = 1'b0;
        chk("n1_valid_b", 32'(out1_valid),  1);
        chk("n1_sum_b",   32'(acc1_sum),    3);
        chk("n1_max_b",   32'(acc1_max),    3);
        chk("n1_ovr",     32'(overrun1),    0);
`ifdef ACC_AVG_EN
        chk("n1_avg_b",   32'(acc1_avg),    3);
`endif
        tick();
        chk("n1_drain",   32'(out1_valid),  0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_result_accum.md
Name: pipe_result_accum

Overview:
Downstream consumer of the 14-bit X result stream produced by the arithmetic pipeline stage.
- Accumulates frames of N_SAMPLES valid results; tracks the running sum and maximum.
- Presents each completed frame's {sum, max} on a valid/ready output port through a single-entry output register.
- The upstream pipeline has no backpressure, so the working accumulator never stalls. Overruns are detected and flagged.

Parameters:
XW, 14, width of incoming result X
N_SAMPLES, 8, samples per frame; legal range 1..256
SUMW, 17, accumulator/output sum width; must be >= XW + clog2(N_SAMPLES)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
x_in  input  XW  result sample from upstream pipeline
x_valid  input  1  x_in carries a valid sample this cycle
acc_sum  output  SUMW  sum of completed frame (registered)
acc_max  output  XW  maximum of completed frame (registered)
out_valid  output  1  acc_sum/acc_max hold an unconsumed frame
out_ready  input  1  consumer accepts frame when out_valid & out_ready
sample_cnt  output  8  samples accumulated in current working frame
overrun  output  1  sticky: a completed frame was dropped

Behaviour:
- Reset (rst=1 at clk edge):
  - Working sum=0, working max=0, sample_cnt=0.
  - acc_sum=0, acc_max=0, out_valid=0, overrun=0.
  - Reset takes priority over every other event, including mid-frame; a partial frame is discarded.
- Working accumulator, evaluated only when x_valid=1:
  - If sample_cnt < N_SAMPLES-1: sum += x_in (zero-extended to SUMW); max = (x_in > max) ? x_in : max; sample_cnt++.
  - If sample_cnt == N_SAMPLES-1, the frame completes this cycle:
    - final_sum = sum + x_in; final_max = max(max, x_in).
    - Working sum, max and sample_cnt all return to 0 in the same cycle, so the next sample starts a new frame with no bubble.
  - No accumulation when x_valid=0; state is held.
- Output register, as a 2-state FSM:
  - EMPTY (out_valid=0):
    - Frame completion loads acc_sum/acc_max and moves to FULL.
    - out_valid rises on the cycle after the final sample, giving 1-cycle latency from the last x_valid.
  - FULL (out_valid=1):
    - acc_sum/acc_max are held stable until the handshake.
    - Handshake with no completion in the same cycle: move to EMPTY.
    - Handshake and completion in the same cycle: load the new frame and stay FULL. No overrun.
    - Completion without handshake: the new frame is dropped, the old frame is kept, overrun is set to 1.
- overrun clears only on rst.
- out_ready is ignored in EMPTY.
- Arithmetic never wraps, given the SUMW rule; x_in is treated as unsigned.
- N_SAMPLES=1: every valid sample completes a frame; sample_cnt stays 0.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
Macro ACC_AVG_EN.
- Defined:
  - Adds output port acc_avg (XW bits), registered alongside acc_sum: acc_avg = final_sum >> clog2(N_SAMPLES), truncating.
  - Reset value 0; held with the frame; same handshake rules.
  - N_SAMPLES must be a power of two; otherwise elaboration fails via $error.
- Undefined: no acc_avg port, no divide logic; all other behaviour is identical.

Test Plan:
- Reset, then N_SAMPLES=8 and x_in=1..8 on 8 consecutive x_valid cycles with out_ready=0.
  - Expect out_valid=1 one cycle after the last sample, acc_sum=36, acc_max=8, sample_cnt=0.
  - With ACC_AVG_EN: acc_avg=4.
- Gapped input: 8 samples of x_in=16383 with x_valid toggling 1/0.
  - Expect acc_sum=131064, acc_max=16383, no wrap; sample_cnt advances only on valid cycles.
- Frame 1 pending, out_ready held 0, second frame of 8×5 completes.
  - Expect overrun=1; acc_sum still 36 from frame 1.
  - Then out_ready=1 for one cycle: out_valid=0.
- Frame 1 pending; assert out_ready in the exact cycle the frame-2 completion registers.
  - Expect out_valid stays 1, acc_sum=40 (8×5), overrun=0.
- Assert rst after 5 samples of a frame.
  - Expect all outputs 0 and sample_cnt=0 next cycle.
  - Then 8 samples of 2: acc_sum=16, proving the partial frame was discarded.
- N_SAMPLES=1 build: x_in=7 then x_in=3, with out_ready=1 continuously.
  - Expect two frames: acc_sum=7, then 3, on consecutive cycles.
